// File: rtl/nios2_debug_slave_cmd_engine.sv
// nios2_debug_slave_cmd_engine
// Single-clock debug-slave command engine. It holds the debug data register
// and performs capture, shift and update on JTAG strobes that have already
// been synchronised. Updates are decoded into per-channel commands: each
// channel has a level request with an acknowledge handshake, a one-cycle
// no-action pulse, and a sticky overrun flag.
`timescale 1ns/1ps
module nios2_debug_slave_cmd_engine #(
  parameter int IR_W    = 2,
  parameter int DR_W    = 38,
  parameter int NCH     = 4,
  parameter int ACT_BIT = 35
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IR_W-1:0]     ir_in,
  input  logic                cap_strb,
  input  logic                shift_strb,
  input  logic                tdi,
  input  logic                upd_strb,
  output logic                tdo,
  input  logic [NCH*DR_W-1:0] chan_status,
  output logic [DR_W-1:0]     jdo,
  output logic [NCH-1:0]      take_action,
  output logic [NCH-1:0]      take_no_action,
  input  logic [NCH-1:0]      action_ack,
  output logic [NCH-1:0]      overrun,
  input  logic                ovr_clr
);

  logic [DR_W-1:0] r_sr;
  logic [DR_W-1:0] r_jdo;
  logic [DR_W-1:0] w_cap_word;
  logic [NCH-1:0]  r_take_action;
  logic [NCH-1:0]  r_take_no_action;
  logic [NCH-1:0]  r_overrun;
  logic [NCH-1:0]  w_sel;
  logic [NCH-1:0]  w_ta_next;
  logic [NCH-1:0]  w_tna_next;
  logic [NCH-1:0]  w_ovr_next;
  logic            w_ir_valid;
  logic            w_upd;
  logic            w_act;

  // One-hot channel select. An instruction that names no implemented
  // channel leaves every select bit low, which turns capture into a load of
  // zero and suppresses the update entirely.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_sel
      assign w_sel[gi] = (ir_in == IR_W'(gi));
    end
  endgenerate

  assign w_ir_valid = |w_sel;
  assign w_upd      = upd_strb & w_ir_valid;
  // Update decodes the register as it stood at the start of the cycle, so a
  // capture or shift in the same cycle cannot alter this update.
  assign w_act      = r_sr[ACT_BIT];

  // Capture word mux: selected channel's status slice, zero when none selected
  always_comb begin
    w_cap_word = '0;
    for (int c = 0; c < NCH; c++) begin
      if (w_sel[c]) begin
        w_cap_word = chan_status[c*DR_W +: DR_W];
      end
    end
  end

  // Per-channel handshake next-state
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      logic w_hit;
      logic w_new_req;
      logic w_ovr_evt;

      assign w_hit     = w_upd & w_sel[gi];
      assign w_new_req = w_hit & w_act;
      // A new request only overruns when the old one is still outstanding
      // and is not retiring in this very cycle.
      assign w_ovr_evt = w_new_req & r_take_action[gi] & ~action_ack[gi];

      // An ack retires the request; a simultaneous new request re-arms it.
      assign w_ta_next[gi]  = w_new_req | (r_take_action[gi] & ~action_ack[gi]);
      assign w_tna_next[gi] = w_hit & ~w_act;
      // A fresh overrun event beats a clear in the same cycle.
      assign w_ovr_next[gi] = w_ovr_evt | (r_overrun[gi] & ~ovr_clr);
    end
  endgenerate

  // Data shift register: capture has priority over shift
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr <= '0;
    end else if (cap_strb) begin
      r_sr <= w_cap_word;
    end else if (shift_strb) begin
      r_sr <= {tdi, r_sr[DR_W-1:1]};
    end
  end

  // Data word presented to the target, refreshed on every accepted update
  always_ff @(posedge clk) begin
    if (reset) begin
      r_jdo <= '0;
    end else if (w_upd) begin
      r_jdo <= r_sr;
    end
  end

  // Command flags: requests, no-action pulses and sticky overruns
  always_ff @(posedge clk) begin
    if (reset) begin
      r_take_action    <= '0;
      r_take_no_action <= '0;
      r_overrun        <= '0;
    end else begin
      r_take_action    <= w_ta_next;
      r_take_no_action <= w_tna_next;
      r_overrun        <= w_ovr_next;
    end
  end

  assign tdo            = r_sr[0];
  assign jdo            = r_jdo;
  assign take_action    = r_take_action;
  assign take_no_action = r_take_no_action;
  assign overrun        = r_overrun;

endmodule

// File: tb/tb_nios2_debug_slave_cmd_engine.sv
// tb_nios2_debug_slave_cmd_engine
// Directed stimulus pushes hand-derived expectations into a scoreboard queue
// tagged with the cycle in which they must hold; a monitor on the falling
// edge pops and compares. A second instance built with NCH=3 covers the
// out-of-range instruction behaviour.
`timescale 1ns/1ps
module tb_nios2_debug_slave_cmd_engine;

  localparam int DR_W = 38;
  localparam int NCH  = 4;

  localparam logic [DR_W-1:0] S0  = 38'h00_0000_0001;
  localparam logic [DR_W-1:0] S1  = 38'h2A_5A5A_5A5A;
  localparam logic [DR_W-1:0] S2  = 38'h15_0F0F_F0F1;  // bit35 = 0
  localparam logic [DR_W-1:0] S3  = 38'h3F_0000_0000;
  localparam logic [DR_W-1:0] W2  = 38'h08_0000_1234;  // bit35 = 1
  localparam logic [DR_W-1:0] W3  = 38'h00_0000_0055;  // bit35 = 0
  localparam logic [DR_W-1:0] W4A = 38'h08_AAAA_0001;  // bit35 = 1
  localparam logic [DR_W-1:0] W4B = 38'h0F_0000_BEEF;  // bit35 = 1

  logic                clk = 1'b0;
  logic                reset0, reset1;
  logic [1:0]          ir_in;
  logic                cap_strb, shift_strb, tdi, upd_strb, ovr_clr;
  logic [NCH*DR_W-1:0] chan_status;
  logic [NCH-1:0]      action_ack;

  logic                tdo0, tdo1;
  logic [DR_W-1:0]     jdo0, jdo1;
  logic [3:0]          ta0, tna0, ovr0;
  logic [2:0]          ta1, tna1, ovr1;

  nios2_debug_slave_cmd_engine #(.IR_W(2), .DR_W(DR_W), .NCH(4), .ACT_BIT(35)) dut (
    .clk(clk), .reset(reset0), .ir_in(ir_in), .cap_strb(cap_strb),
    .shift_strb(shift_strb), .tdi(tdi), .upd_strb(upd_strb), .tdo(tdo0),
    .chan_status(chan_status), .jdo(jdo0), .take_action(ta0),
    .take_no_action(tna0), .action_ack(action_ack), .overrun(ovr0),
    .ovr_clr(ovr_clr)
  );

  nios2_debug_slave_cmd_engine #(.IR_W(2), .DR_W(DR_W), .NCH(3), .ACT_BIT(35)) dut_n3 (
    .clk(clk), .reset(reset1), .ir_in(ir_in), .cap_strb(cap_strb),
    .shift_strb(shift_strb), .tdi(tdi), .upd_strb(upd_strb), .tdo(tdo1),
    .chan_status(chan_status[3*DR_W-1:0]), .jdo(jdo1), .take_action(ta1),
    .take_no_action(tna1), .action_ack(action_ack[2:0]), .overrun(ovr1),
    .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          which;
    string       name;
    logic [50:0] v;   // {tdo, jdo, take_action, take_no_action, overrun}
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          stim_done = 1'b0;
  int          done_cyc = 0;

  // Expected state of the instance currently being checked
  logic [DR_W-1:0] e_sr, e_jdo;
  logic [3:0]      e_ta, e_tna, e_ovr;

  exp_t        m_e;
  logic [50:0] m_act;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation that falls due in this cycle
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      m_e = sb_q.pop_front();
      if (m_e.which == 0)
        m_act = {tdo0, jdo0, ta0, tna0, ovr0};
      else
        m_act = {tdo1, jdo1, 1'b0, ta1, 1'b0, tna1, 1'b0, ovr1};
      n_checks++;
      if (m_act !== m_e.v) begin
        n_fail++;
        $display("FAIL %s: got tdo=%b jdo=%h ta=%b tna=%b ovr=%b, expected tdo=%b jdo=%h ta=%b tna=%b ovr=%b",
                 m_e.name, m_act[50], m_act[49:12], m_act[11:8], m_act[7:4], m_act[3:0],
                 m_e.v[50], m_e.v[49:12], m_e.v[11:8], m_e.v[7:4], m_e.v[3:0]);
      end else begin
        $display("ok   %s: tdo=%b jdo=%h ta=%b tna=%b ovr=%b",
                 m_e.name, m_act[50], m_act[49:12], m_act[11:8], m_act[7:4], m_act[3:0]);
      end
    end
    if (stim_done && sb_q.size() > 0 && cyc > done_cyc + 4) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations never compared, expected 0", sb_q.size());
      sb_q.delete();
    end
  end

  task automatic push(input string name, input int which);
    exp_t e;
    e.cyc   = cyc;
    e.which = which;
    e.name  = name;
    e.v     = {e_sr[0], e_jdo, e_ta, e_tna, e_ovr};
    sb_q.push_back(e);
  endtask

  // Advance one clock; inputs set before the call are sampled on this edge
  task automatic step();
    e_tna = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input logic [1:0] ir, input logic [DR_W-1:0] word);
    ir_in = ir; cap_strb = 1'b1;
    step();
    cap_strb = 1'b0;
    e_sr = word;
  endtask

  task automatic shift1(input logic b);
    tdi = b; shift_strb = 1'b1;
    step();
    shift_strb = 1'b0; tdi = 1'b0;
    e_sr = {b, e_sr[DR_W-1:1]};
  endtask

  task automatic shift_word(input logic [DR_W-1:0] w);
    for (int i = 0; i < DR_W; i++) shift1(w[i]);
  endtask

  task automatic upd(input logic [1:0] ir);
    ir_in = ir; upd_strb = 1'b1;
    step();
    upd_strb = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset0 = 1'b1; reset1 = 1'b1; ir_in = '0; cap_strb = 1'b0; shift_strb = 1'b0;
    tdi = 1'b0; upd_strb = 1'b0; ovr_clr = 1'b0; action_ack = '0;
    chan_status = {S3, S2, S1, S0};
    e_sr = '0; e_jdo = '0; e_ta = '0; e_tna = '0; e_ovr = '0;

    // Reset state of both instances
    step(); step();
    push("reset_dut", 0);
    push("reset_dut_n3", 1);
    reset0 = 1'b0;

    // Capture channel 1 and read it out LSB first
    cap(2'd1, S1);
    push("t1_cap", 0);
    for (int k = 1; k <= DR_W; k++) begin
      shift1(1'b0);
      push($sformatf("t1_shift%0d", k), 0);
    end

    // Action update on channel 2
    shift_word(W2);
    push("t2_loaded", 0);
    upd(2'd2);
    e_jdo = W2; e_ta = 4'b0100;
    push("t2_update", 0);

    // Ack, ack while idle, then a no-action update on channel 0
    action_ack = 4'b0100; step(); action_ack = '0;
    e_ta = 4'b0000;
    push("t3_ack", 0);
    action_ack = 4'b0100; step(); action_ack = '0;
    push("t3_ack_idle", 0);
    shift_word(W3);
    upd(2'd0);
    e_jdo = W3; e_tna = 4'b0001;
    push("t3_noact", 0);
    step();
    push("t3_pulse_end", 0);

    // Overrun on channel 3 and clearing it
    shift_word(W4A);
    upd(2'd3);
    e_jdo = W4A; e_ta = 4'b1000;
    push("t4_first", 0);
    shift_word(W4B);
    upd(2'd3);
    e_jdo = W4B; e_ovr = 4'b1000;
    push("t4_overrun", 0);
    ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
    e_ovr = 4'b0000;
    push("t4_ovr_clr", 0);
    shift_word(W4A);
    ovr_clr = 1'b1;
    upd(2'd3);
    ovr_clr = 1'b0;
    e_jdo = W4A; e_ovr = 4'b1000;
    push("t4_clr_vs_event", 0);
    ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
    e_ovr = 4'b0000;
    push("t4_ovr_clr2", 0);

    // Update with simultaneous ack: old request retires, new one accepted
    shift_word(W4B);
    action_ack = 4'b1000;
    upd(2'd3);
    action_ack = '0;
    e_jdo = W4B;
    push("t5_upd_with_ack", 0);
    step();
    push("t5_still_pending", 0);
    shift_word(W3);
    upd(2'd3);
    e_jdo = W3; e_tna = 4'b1000;
    push("t5_noact_on_pending", 0);
    action_ack = 4'b1000; step(); action_ack = '0;
    e_ta = 4'b0000;
    push("t5_ack3", 0);

    // Reset mid-shift, overriding shift and update in the same cycle
    for (int k = 0; k < 20; k++) shift1(1'b1);
    reset0 = 1'b1; shift_strb = 1'b1; tdi = 1'b1; upd_strb = 1'b1; ir_in = 2'd2;
    step();
    reset0 = 1'b0; shift_strb = 1'b0; tdi = 1'b0; upd_strb = 1'b0;
    e_sr = '0; e_jdo = '0; e_ta = '0; e_ovr = '0;
    push("t6_reset_midshift", 0);
    upd(2'd1);
    e_jdo = '0; e_tna = 4'b0010;
    push("t6_sr_cleared", 0);
    ir_in = 2'd2; cap_strb = 1'b1; shift_strb = 1'b1; tdi = 1'b0;
    step();
    cap_strb = 1'b0; shift_strb = 1'b0;
    e_sr = S2;
    push("t6_cap_beats_shift", 0);
    upd(2'd2);
    e_jdo = S2; e_tna = 4'b0100;
    push("t6_cap_word_update", 0);

    // NCH=3 instance: instruction 3 addresses no channel
    reset1 = 1'b0;
    e_sr = '0; e_jdo = '0; e_ta = '0; e_tna = '0; e_ovr = '0;
    cap(2'd0, S0);
    push("n3_cap0", 1);
    cap(2'd3, '0);
    push("n3_cap_oob", 1);
    shift_word(W2);
    upd(2'd0);
    e_jdo = W2; e_ta = 4'b0001;
    push("n3_upd0", 1);
    shift_word(W4B);
    upd(2'd3);
    push("n3_upd_oob_act", 1);
    shift_word(W3);
    upd(2'd3);
    push("n3_upd_oob_noact", 1);

    stim_done = 1'b1;
    done_cyc  = cyc;
    repeat (8) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
